// File: rtl/sd_spi_cmd_controller.sv
// SD-over-SPI command sequencer: decodes received frames, tracks card init state, streams responses.
// Optional: define SD_CMD58_EN to answer CMD58 (READ_OCR) with an R3 response.
module sd_spi_cmd_controller #(
  parameter int unsigned NCR_BYTES     = 1,
  parameter int unsigned ACMD41_POLLS  = 2,
  parameter int unsigned MAX_BLOCK_LEN = 512
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_ArgumentReadFinished,
  input  logic        io_ReadSuccess,
  input  logic [5:0]  io_Command,
  input  logic [31:0] io_CommandArgument,
  output logic        io_RespValid,
  output logic [7:0]  io_RespByte,
  input  logic        io_RespReady,
  output logic        io_Idle,
  output logic        io_Ready,
  output logic [11:0] io_BlockLength,
  output logic        io_Overrun
);

  typedef enum logic [2:0] {StOff, StWait, StDecode, StNcr, StResp} state_e;

  state_e           state_q, state_d;
  logic             arf_q, arf_qq;
  logic             frame_rise;
  logic [5:0]       cmd_q, cmd_d;
  logic [31:0]      arg_q, arg_d;
  logic             ok_q, ok_d;
  logic [4:0][7:0]  resp_q, resp_d;
  logic [2:0]       len_q, len_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             idle_q, idle_d;
  logic             ready_q, ready_d;
  logic             app_q, app_d;
  logic             init_q, init_d;
  logic [7:0]       poll_q, poll_d;
  logic [11:0]      blen_q, blen_d;
  logic             overrun_q, overrun_d;
  logic             hs;
  logic [7:0]       r1_idle;

  assign frame_rise = arf_q & ~arf_qq;
  assign r1_idle    = {7'b0, idle_q};

  assign io_RespValid   = (state_q == StNcr) || (state_q == StResp);
  assign io_RespByte    = (state_q == StResp) ? resp_q[cnt_q[2:0]] : 8'hFF;
  assign io_Idle        = idle_q;
  assign io_Ready       = ready_q;
  assign io_BlockLength = blen_q;
  assign io_Overrun     = overrun_q;
  assign hs             = io_RespValid & io_RespReady;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StOff;
      arf_q     <= 1'b0;
      arf_qq    <= 1'b0;
      cmd_q     <= '0;
      arg_q     <= '0;
      ok_q      <= 1'b0;
      resp_q    <= '0;
      len_q     <= 3'd1;
      cnt_q     <= '0;
      idle_q    <= 1'b0;
      ready_q   <= 1'b0;
      app_q     <= 1'b0;
      init_q    <= 1'b0;
      poll_q    <= '0;
      blen_q    <= 12'(MAX_BLOCK_LEN);
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      arf_q     <= io_ArgumentReadFinished;
      arf_qq    <= arf_q;
      cmd_q     <= cmd_d;
      arg_q     <= arg_d;
      ok_q      <= ok_d;
      resp_q    <= resp_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      idle_q    <= idle_d;
      ready_q   <= ready_d;
      app_q     <= app_d;
      init_q    <= init_d;
      poll_q    <= poll_d;
      blen_q    <= blen_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    arg_d     = arg_q;
    ok_d      = ok_q;
    resp_d    = resp_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    idle_d    = idle_q;
    ready_d   = ready_q;
    app_d     = app_q;
    init_d    = init_q;
    poll_d    = poll_q;
    blen_d    = blen_q;
    overrun_d = 1'b0;

    // A frame can only be taken while nothing is pending; otherwise it is dropped.
    if (frame_rise) begin
      if (state_q == StOff || state_q == StWait) begin
        cmd_d   = io_Command;
        arg_d   = io_CommandArgument;
        ok_d    = io_ReadSuccess;
        state_d = StDecode;
      end else begin
        overrun_d = 1'b1;
      end
    end

    unique case (state_q)
      StDecode: begin
        state_d = StNcr;
        cnt_d   = '0;
        len_d   = 3'd1;
        resp_d  = '0;
        app_d   = 1'b0;
        if (!init_q && !(ok_q && cmd_q == 6'd0)) begin
          // Card is still powered-off: anything but a clean CMD0 is silently ignored.
          state_d = StOff;
        end else if (!ok_q) begin
          resp_d[0] = 8'h08 | r1_idle;
        end else if (cmd_q == 6'd0) begin
          init_d    = 1'b1;
          idle_d    = 1'b1;
          ready_d   = 1'b0;
          poll_d    = '0;
          resp_d[0] = 8'h01;
        end else if (cmd_q == 6'd8) begin
          len_d     = 3'd5;
          resp_d[0] = r1_idle;
          resp_d[3] = (arg_q[11:8] == 4'h1) ? 8'h01 : 8'h00;
          resp_d[4] = arg_q[7:0];
        end else if (cmd_q == 6'd55) begin
          app_d     = 1'b1;
          resp_d[0] = r1_idle;
        end else if (cmd_q == 6'd41 && app_q) begin
          if (32'(poll_q) < ACMD41_POLLS) begin
            poll_d    = poll_q + 8'd1;
            resp_d[0] = 8'h01;
          end else begin
            idle_d    = 1'b0;
            ready_d   = 1'b1;
            resp_d[0] = 8'h00;
          end
        end else if (cmd_q == 6'd16) begin
          if (arg_q != 32'd0 && arg_q <= 32'(MAX_BLOCK_LEN)) begin
            blen_d    = arg_q[11:0];
            resp_d[0] = r1_idle;
          end else begin
            resp_d[0] = 8'h40 | r1_idle;
          end
`ifdef SD_CMD58_EN
        end else if (cmd_q == 6'd58) begin
          len_d     = 3'd5;
          resp_d[0] = r1_idle;
          resp_d[1] = ready_q ? 8'hC0 : 8'h00;
          resp_d[2] = 8'hFF;
          resp_d[3] = 8'h80;
          resp_d[4] = 8'h00;
`endif
        end else begin
          resp_d[0] = 8'h04 | r1_idle;
        end
      end
      StNcr: begin
        if (hs) begin
          if (cnt_q == 4'(NCR_BYTES - 1)) begin
            state_d = StResp;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StResp: begin
        if (hs) begin
          if (cnt_q[2:0] == len_q - 3'd1) begin
            state_d = StWait;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sd_spi_cmd_controller.sv
// Self-checking bench for sd_spi_cmd_controller: frame-level card model plus a per-cycle byte monitor.
module tb_sd_spi_cmd_controller;

  localparam int unsigned NCR  = 1;
  localparam int unsigned POLLS = 2;
  localparam int unsigned MAXB = 512;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_ArgumentReadFinished = 1'b0;
  logic        io_ReadSuccess = 1'b0;
  logic [5:0]  io_Command = '0;
  logic [31:0] io_CommandArgument = '0;
  logic        io_RespValid;
  logic [7:0]  io_RespByte;
  logic        io_RespReady = 1'b1;
  logic        io_Idle;
  logic        io_Ready;
  logic [11:0] io_BlockLength;
  logic        io_Overrun;

  sd_spi_cmd_controller #(
    .NCR_BYTES    (NCR),
    .ACMD41_POLLS (POLLS),
    .MAX_BLOCK_LEN(MAXB)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .io_ArgumentReadFinished(io_ArgumentReadFinished),
    .io_ReadSuccess         (io_ReadSuccess),
    .io_Command             (io_Command),
    .io_CommandArgument     (io_CommandArgument),
    .io_RespValid           (io_RespValid),
    .io_RespByte            (io_RespByte),
    .io_RespReady           (io_RespReady),
    .io_Idle                (io_Idle),
    .io_Ready               (io_Ready),
    .io_BlockLength         (io_BlockLength),
    .io_Overrun             (io_Overrun)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  // Card model
  bit         m_init, m_idle, m_ready, m_app;
  int         m_poll;
  logic [11:0] m_blen;

  function automatic void check(string name, logic [47:0] got, logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endfunction

  function automatic void model_reset();
    m_init = 0; m_idle = 0; m_ready = 0; m_app = 0; m_poll = 0; m_blen = 12'(MAXB);
    exp_q.delete();
  endfunction

  // Predicts the byte stream for one accepted frame and updates the card state.
  function automatic bit model_frame(logic [5:0] cmd, logic [31:0] arg, logic ok);
    logic [7:0] r[$];
    logic [7:0] idl;
    idl = {7'b0, m_idle};
    if (!m_init && !(ok && cmd == 6'd0)) return 1'b0;
    if (!ok) r.push_back(8'h08 | idl);
    else if (cmd == 6'd0) begin
      m_init = 1; m_idle = 1; m_ready = 0; m_poll = 0;
      r.push_back(8'h01);
    end else if (cmd == 6'd8) begin
      r.push_back(idl); r.push_back(8'h00); r.push_back(8'h00);
      r.push_back((arg[11:8] == 4'h1) ? 8'h01 : 8'h00);
      r.push_back(arg[7:0]);
    end else if (cmd == 6'd55) r.push_back(idl);
    else if (cmd == 6'd41 && m_app) begin
      if (m_poll < int'(POLLS)) begin m_poll++; r.push_back(8'h01); end
      else begin m_idle = 0; m_ready = 1; r.push_back(8'h00); end
    end else if (cmd == 6'd16) begin
      if (arg >= 1 && arg <= MAXB) begin m_blen = arg[11:0]; r.push_back(idl); end
      else r.push_back(8'h40 | idl);
    end
`ifdef SD_CMD58_EN
    else if (cmd == 6'd58) begin
      r.push_back(idl); r.push_back(m_ready ? 8'hC0 : 8'h00);
      r.push_back(8'hFF); r.push_back(8'h80); r.push_back(8'h00);
    end
`endif
    else r.push_back(8'h04 | idl);
    m_app = ok && (cmd == 6'd55);
    for (int i = 0; i < int'(NCR); i++) exp_q.push_back(8'hFF);
    foreach (r[i]) exp_q.push_back(r[i]);
    return 1'b1;
  endfunction

  // Per-cycle output check against the predicted byte stream.
  always @(negedge clock) begin
    if (!reset && io_RespValid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid: byte %02h while no response expected", io_RespByte);
      end else begin
        check("resp_byte", 48'(io_RespByte), 48'(exp_q[0]));
        if (io_RespReady) begin
          got_q.push_back(io_RespByte);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic status_check(string name);
    check({name, "_idle"}, 48'(io_Idle), 48'(m_idle));
    check({name, "_ready"}, 48'(io_Ready), 48'(m_ready));
    check({name, "_blen"}, 48'(io_BlockLength), 48'(m_blen));
    check({name, "_overrun"}, 48'(io_Overrun), 48'd0);
  endtask

  task automatic check_lit(string name, int n, logic [47:0] lit);
    check({name, "_len"}, 48'(got_q.size()), 48'(n));
    if (got_q.size() == n)
      for (int i = 0; i < n; i++)
        check({name, "_lit"}, 48'(got_q[i]), 48'(lit[8*(n-1-i) +: 8]));
  endtask

  task automatic drain(string name, bit bp);
    int n = 0;
    while (n < 200 && (exp_q.size() != 0 || io_RespValid)) begin
      @(posedge clock); #1; n++;
      if (bp) io_RespReady = 1'($urandom_range(0, 1));
    end
    check({name, "_drained"}, 48'(n < 200), 48'd1);
    io_RespReady = 1'b1;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic send(string name, logic [5:0] cmd, logic [31:0] arg, logic ok, bit bp);
    bit resp;
    bit seen = 0;
    int n = 0;
    got_q.delete();
    resp = model_frame(cmd, arg, ok);
    io_Command = cmd; io_CommandArgument = arg; io_ReadSuccess = ok;
    io_ArgumentReadFinished = 1'b1;
    while (n < 10 && !seen) begin
      @(posedge clock); #1; n++;
      seen = io_RespValid;
      if (bp) io_RespReady = 1'($urandom_range(0, 1));
    end
    if (resp) check({name, "_latency"}, 48'(n), 48'd3);
    else      check({name, "_silent"}, 48'(seen), 48'd0);
    io_ArgumentReadFinished = 1'b0;
    drain(name, bp);
    status_check(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_valid", 48'(io_RespValid), 48'd0);
    check("rst_byte", 48'(io_RespByte), 48'hFF);
    check("rst_overrun", 48'(io_Overrun), 48'd0);
    status_check("rst");
    check("rst_blen_lit", 48'(io_BlockLength), 48'd512);

    send("off_cmd8", 6'd8, 32'h1AA, 1'b1, 0);
    send("off_cmd0_bad", 6'd0, 32'h0, 1'b0, 0);
    send("cmd0", 6'd0, 32'h0, 1'b1, 0);
    check_lit("cmd0", 2, 48'hFF01);
    check("cmd0_idle_lit", 48'(io_Idle), 48'd1);
    send("cmd8", 6'd8, 32'h1AA, 1'b1, 0);
    check_lit("cmd8", 6, 48'hFF01_0000_01AA);
    send("cmd8_v2", 6'd8, 32'h2AA, 1'b1, 1);
    check_lit("cmd8_v2", 6, 48'hFF01_0000_00AA);
    send("cmd16_512", 6'd16, 32'd512, 1'b1, 0);
    check_lit("cmd16_512", 2, 48'hFF01);
    send("cmd16_1024", 6'd16, 32'd1024, 1'b1, 0);
    check_lit("cmd16_1024", 2, 48'hFF41);
    check("cmd16_1024_blen_lit", 48'(io_BlockLength), 48'd512);
    send("cmd16_0", 6'd16, 32'd0, 1'b1, 0);
    send("cmd16_64", 6'd16, 32'd64, 1'b1, 1);
    check("cmd16_64_blen_lit", 48'(io_BlockLength), 48'd64);
    send("cmd55a", 6'd55, 32'd0, 1'b1, 0);
    send("cmd55b", 6'd55, 32'd0, 1'b1, 0);
    check_lit("cmd55b", 2, 48'hFF01);
    send("cmd16_app", 6'd16, 32'd512, 1'b1, 0);
    check_lit("cmd16_app", 2, 48'hFF01);
    send("cmd41_noapp_idle", 6'd41, 32'd0, 1'b1, 0);
    check_lit("cmd41_noapp_idle", 2, 48'hFF05);
    send("bad_crc", 6'd17, 32'd0, 1'b0, 0);
    check_lit("bad_crc", 2, 48'hFF09);
    for (int i = 0; i < 3; i++) begin
      send("acmd_55", 6'd55, 32'd0, 1'b1, i == 1);
      send("acmd41", 6'd41, 32'h4000_0000, 1'b1, i == 1);
    end
    check_lit("acmd41_last", 2, 48'hFF00);
    check("acmd41_ready_lit", 48'({io_Ready, io_Idle}), 48'b10);
    send("cmd41_noapp_ready", 6'd41, 32'd0, 1'b1, 0);
    check_lit("cmd41_noapp_ready", 2, 48'hFF04);
    send("acmd_55r", 6'd55, 32'd0, 1'b1, 0);
    send("acmd41_ready", 6'd41, 32'd0, 1'b1, 0);
    check_lit("acmd41_ready", 2, 48'hFF00);
    send("cmd58", 6'd58, 32'd0, 1'b1, 0);
`ifdef SD_CMD58_EN
    check_lit("cmd58", 6, 48'hFF00_C0FF_8000);
`else
    check_lit("cmd58", 2, 48'hFF04);
`endif
    send("cmd0_again", 6'd0, 32'd0, 1'b1, 0);
    send("acmd_55p", 6'd55, 32'd0, 1'b1, 0);
    send("acmd41_repoll", 6'd41, 32'd0, 1'b1, 0);
    check_lit("acmd41_repoll", 2, 48'hFF01);

    // Frame arriving while the response byte is stalled.
    begin
      int n = 0;
      int pulses = 0;
      got_q.delete();
      io_RespReady = 1'b0;
      void'(model_frame(6'd16, 32'd64, 1'b1));
      io_Command = 6'd16; io_CommandArgument = 32'd64; io_ReadSuccess = 1'b1;
      io_ArgumentReadFinished = 1'b1;
      while (n < 20 && !io_RespValid) begin @(posedge clock); #1; n++; end
      check("ovr_fill_valid", 48'(io_RespValid), 48'd1);
      io_RespReady = 1'b1;
      @(posedge clock); #1;
      io_RespReady = 1'b0;
      io_ArgumentReadFinished = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      io_Command = 6'd0; io_CommandArgument = 32'd0;
      io_ArgumentReadFinished = 1'b1;
      for (int i = 0; i < 8; i++) begin
        @(posedge clock); #1;
        if (io_Overrun) pulses++;
      end
      check("ovr_pulses", 48'(pulses), 48'd1);
      io_ArgumentReadFinished = 1'b0;
      io_RespReady = 1'b1;
      drain("ovr", 0);
      check_lit("ovr", 2, 48'hFF01);
      status_check("ovr");
    end

    // Asynchronous reset in the middle of a response.
    begin
      int n = 0;
      io_RespReady = 1'b0;
      void'(model_frame(6'd8, 32'h1AA, 1'b1));
      io_Command = 6'd8; io_CommandArgument = 32'h1AA; io_ReadSuccess = 1'b1;
      io_ArgumentReadFinished = 1'b1;
      while (n < 20 && !io_RespValid) begin @(posedge clock); #1; n++; end
      check("arst_pre_valid", 48'(io_RespValid), 48'd1);
      #2 reset = 1'b1;
      #1;
      model_reset();
      check("arst_valid", 48'(io_RespValid), 48'd0);
      check("arst_byte", 48'(io_RespByte), 48'hFF);
      status_check("arst");
      io_ArgumentReadFinished = 1'b0;
      io_RespReady = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      send("post_arst_cmd8", 6'd8, 32'h1AA, 1'b1, 0);
      send("post_arst_cmd0", 6'd0, 32'd0, 1'b1, 0);
      check_lit("post_arst_cmd0", 2, 48'hFF01);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
